// File: rtl/aes_shift_rows_pipe.sv
// aes_shift_rows_pipe: pipelined, flow-controlled AES ShiftRows / InvShiftRows.
// The permutation is applied combinationally in front of stage 0. Stages
// 1..DEPTH-1 carry data unchanged. Block_count counts output handshakes.
// Optional feature macro: AES_SHIFT_ROWS_PIPE_BYPASS_EN adds a per-beat Bypass
// input that passes the block through unpermuted.

`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

module aes_shift_rows_pipe #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       In_valid,
    output logic                       In_ready,
    input  logic                       Encrypt,
`ifdef AES_SHIFT_ROWS_PIPE_BYPASS_EN
    input  logic                       Bypass,
`endif
    input  logic [`AES_BLOCK_SIZE-1:0] Input_block,
    output logic                       Out_valid,
    input  logic                       Out_ready,
    output logic [`AES_BLOCK_SIZE-1:0] Output_block,
    output logic [COUNT_WIDTH-1:0]     Block_count,
    output logic                       Busy
);

    localparam int unsigned BW = `AES_BLOCK_SIZE;

    // Elaboration-time guard on the pipeline depth
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("aes_shift_rows_pipe: DEPTH must be in 1..8");
    end

    // Byte i sits at row i%4, column i/4. Encrypt rotates row r left by r;
    // decrypt rotates it right by r.
    function automatic logic [BW-1:0] shift_rows(input logic [BW-1:0] blk, input logic enc);
        logic [BW-1:0] res;
        int unsigned   src_col;
        res = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                src_col = enc ? ((c + r) % 4) : ((c + 4 - r) % 4);
                res[8*(r + 4*c) +: 8] = blk[8*(r + 4*src_col) +: 8];
            end
        end
        return res;
    endfunction

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_nx;
    logic [DEPTH-1:0] adv;
    logic [BW-1:0]    data_q [DEPTH];
    logic [BW-1:0]    perm_in;

    // Permuted (or bypassed) input block feeding stage 0
`ifdef AES_SHIFT_ROWS_PIPE_BYPASS_EN
    assign perm_in = Bypass ? Input_block : shift_rows(Input_block, Encrypt);
`else
    assign perm_in = shift_rows(Input_block, Encrypt);
`endif

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic          vin;
        logic [BW-1:0] din;
        logic          v_q;
        logic [BW-1:0] d_q;

        if (s == 0) begin : g_head
            assign vin = In_valid;
            assign din = perm_in;
        end else begin : g_body
            assign vin = valid_q[s-1];
            assign din = data_q[s-1];
        end

        // Stage s may load when it or any later stage is empty, or the tail drains
        assign adv[s] = Out_ready || !(&valid_q[DEPTH-1:s]);

        // Stage register: valid always follows on advance, data only for valid beats
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (adv[s]) begin
                v_q <= vin;
                if (vin) begin
                    d_q <= din;
                end
            end
        end

        assign valid_q[s]  = v_q;
        assign data_q[s]   = d_q;
        assign valid_nx[s] = adv[s] ? vin : v_q;
    end

    assign In_ready     = adv[0];
    assign Out_valid    = valid_q[DEPTH-1];
    assign Output_block = data_q[DEPTH-1];

    // Output handshake counter, wraps silently
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Block_count <= '0;
        end else if (Out_valid && Out_ready) begin
            Block_count <= Block_count + COUNT_WIDTH'(1);
        end
    end

    // Busy tracks next-cycle occupancy so it lines up with the stage valids
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Busy <= 1'b0;
        end else begin
            Busy <= |valid_nx;
        end
    end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Bench for aes_shift_rows_pipe: scoreboard of expected blocks, directed steps.

`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

module tb_aes_shift_rows_pipe;

    localparam int unsigned A_DEPTH = 2;
    localparam int unsigned B_DEPTH = 3;
    localparam int unsigned B_CW    = 4;

    localparam int ENC_SRC [16] = '{11, 6, 1, 12, 7, 2, 13, 8, 3, 14, 9, 4, 15, 10, 5, 0};
    localparam int DEC_SRC [16] = '{3, 6, 9, 12, 15, 2, 5, 8, 11, 14, 1, 4, 7, 10, 13, 0};
    localparam logic [127:0] SEQ_BLK = 128'h0f0e0d0c0b0a09080706050403020100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         a_in_valid, a_in_ready, a_enc, a_bypass;
    logic [127:0] a_in, a_out;
    logic         a_out_valid, a_out_ready, a_ready_drv, a_busy;
    logic [15:0]  a_count;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_out;
    logic [B_CW-1:0] b_count;
    logic         chain_mode;

    assign a_out_ready = chain_mode ? b_in_ready : a_ready_drv;
    assign b_in_valid  = chain_mode && a_out_valid;

    aes_shift_rows_pipe #(.DEPTH(A_DEPTH), .COUNT_WIDTH(16)) u_a (
        .Clk(clk), .Rst_n(rst_n),
        .In_valid(a_in_valid), .In_ready(a_in_ready), .Encrypt(a_enc),
`ifdef AES_SHIFT_ROWS_PIPE_BYPASS_EN
        .Bypass(a_bypass),
`endif
        .Input_block(a_in), .Out_valid(a_out_valid), .Out_ready(a_out_ready),
        .Output_block(a_out), .Block_count(a_count), .Busy(a_busy)
    );

    aes_shift_rows_pipe #(.DEPTH(B_DEPTH), .COUNT_WIDTH(B_CW)) u_b (
        .Clk(clk), .Rst_n(rst_n),
        .In_valid(b_in_valid), .In_ready(b_in_ready), .Encrypt(1'b0),
`ifdef AES_SHIFT_ROWS_PIPE_BYPASS_EN
        .Bypass(1'b0),
`endif
        .Input_block(a_out), .Out_valid(b_out_valid), .Out_ready(b_out_ready),
        .Output_block(b_out), .Block_count(b_count), .Busy(b_busy)
    );

    int errors = 0;
    int checks = 0;
    longint cyc = 0;
    logic [127:0] a_q [$];
    logic [127:0] b_q [$];

    // back-to-back window statistics
    bit     bb_win = 1'b0;
    int     bb_n = 0;
    longint bb_first = 0, bb_last = 0;

    // streaming state
    logic [127:0] s_cur;
    logic         s_enc;
    bit           stall_mon = 1'b0;
    logic [127:0] stall_exp;
    int           stall_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] perm(input logic [127:0] x, input logic enc);
        logic [127:0] r;
        int src;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            src = enc ? ENC_SRC[15-j] : DEC_SRC[15-j];
            r[8*j +: 8] = x[8*src +: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on input accept, pop/compare on output handshake
    always @(negedge clk) begin
        logic [127:0] x;
        if (rst_n === 1'b1) begin
            if (a_out_valid && a_out_ready) begin
                if (a_q.size() == 0) chk("a_unexpected_out", 128'(a_out_valid), 128'd0);
                else begin
                    x = a_q.pop_front();
                    chk("a_out", a_out, x);
                end
                if (bb_win) begin
                    if (bb_n == 0) bb_first = cyc;
                    bb_last = cyc;
                    bb_n++;
                end
            end
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) chk("b_unexpected_out", 128'(b_out_valid), 128'd0);
                else begin
                    x = b_q.pop_front();
                    chk("b_out", b_out, x);
                end
            end
            if (a_in_valid && a_in_ready) begin
                x = a_bypass ? a_in : perm(a_in, a_enc);
                a_q.push_back(x);
                if (chain_mode) b_q.push_back(perm(x, 1'b0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] blk, input logic enc, output logic first_try);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        first_try = 1'b0;
        a_in_valid = 1'b1;
        a_in = blk;
        a_enc = enc;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = a_in_ready;
            if (n == 0) first_try = acc;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 128'(acc), 128'd1);
        a_in_valid = 1'b0;
    endtask

    task automatic stream_cycles(input int n, output int accepted);
        bit acc;
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            a_in_valid = 1'b1;
            a_in = s_cur;
            a_enc = s_enc;
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk);
            #1;
            if (stall_mon && a_out_valid && (a_out !== stall_exp)) stall_bad++;
            if (acc) begin
                accepted++;
                s_cur = rand128();
                s_enc = ~s_enc;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((a_q.size() + b_q.size()) != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_left", 128'(a_q.size() + b_q.size()), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic ft;
        int   acc_n;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in = '0; a_enc = 1'b0; a_bypass = 1'b0;
        a_ready_drv = 1'b1; b_out_ready = 1'b1; chain_mode = 1'b0;
        s_cur = '0; s_enc = 1'b0; stall_exp = '0;

        // reset state
        repeat (2) tick();
        chk("rst_out_valid", 128'(a_out_valid), 128'd0);
        chk("rst_out_block", a_out, 128'd0);
        chk("rst_count", 128'(a_count), 128'd0);
        chk("rst_busy", 128'(a_busy), 128'd0);
        chk("rst_in_ready", 128'(a_in_ready), 128'd1);
        chk("rst_b_count", 128'(b_count), 128'd0);
        rst_n = 1'b1;
        tick();

        // directed encrypt block: latency DEPTH, known result
        send(SEQ_BLK, 1'b1, ft);
        chk("enc_early_valid", 128'(a_out_valid), 128'd0);
        tick();
        chk("enc_lat_valid", 128'(a_out_valid), 128'd1);
        chk("enc_block", a_out, 128'h0b06010c07020d08030e09040f0a0500);
        tick();
        chk("enc_count", 128'(a_count), 128'd1);
        chk("enc_after_valid", 128'(a_out_valid), 128'd0);

        // directed decrypt block
        send(SEQ_BLK, 1'b0, ft);
        tick();
        chk("dec_block", a_out, 128'h0306090c0f0205080b0e0104070a0d00);
        tick();
        chk("dec_count", 128'(a_count), 128'd2);

        // 20 back-to-back random blocks, alternating mode
        bb_n = 0;
        bb_win = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(rand128(), 1'(i % 2), ft);
            chk("bb_in_ready", 128'(ft), 128'd1);
        end
        drain();
        bb_win = 1'b0;
        chk("bb_outputs", 128'(bb_n), 128'd20);
        chk("bb_consecutive", 128'(bb_last - bb_first), 128'd19);
        chk("bb_count", 128'(a_count), 128'd22);

        // stall: Out_ready low for 10 cycles while streaming
        s_cur = rand128();
        s_enc = 1'b1;
        stall_exp = perm(s_cur, s_enc);
        stall_bad = 0;
        a_ready_drv = 1'b0;
        stall_mon = 1'b1;
        stream_cycles(10, acc_n);
        stall_mon = 1'b0;
        chk("stall_accepted", 128'(acc_n), 128'(A_DEPTH));
        chk("stall_in_ready", 128'(a_in_ready), 128'd0);
        chk("stall_out_valid", 128'(a_out_valid), 128'd1);
        chk("stall_busy", 128'(a_busy), 128'd1);
        chk("stall_block", a_out, stall_exp);
        chk("stall_stable", 128'(stall_bad), 128'd0);
        a_ready_drv = 1'b1;
        #1;
        chk("release_in_ready", 128'(a_in_ready), 128'd1);
        stream_cycles(6, acc_n);
        chk("release_accepted", 128'(acc_n), 128'd6);
        chk("release_busy", 128'(a_busy), 128'd1);
        a_in_valid = 1'b0;
        drain();
        chk("stall_count", 128'(a_count), 128'd30);

        // chained inverse instance: round trip and 4-bit count wrap
        chain_mode = 1'b1;
        for (int i = 0; i < 19; i++) send(rand128(), 1'b1, ft);
        drain();
        chk("chain_b_count_wrap", 128'(b_count), 128'd3);
        chk("chain_b_busy", 128'(b_busy), 128'd0);
        chain_mode = 1'b0;

        // reset while the pipe is full
        a_ready_drv = 1'b0;
        s_cur = rand128();
        stream_cycles(6, acc_n);
        chk("prerst_full", 128'(a_in_ready), 128'd0);
        rst_n = 1'b0;
        a_in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(a_out_valid), 128'd0);
        chk("midrst_busy", 128'(a_busy), 128'd0);
        chk("midrst_count", 128'(a_count), 128'd0);
        chk("midrst_in_ready", 128'(a_in_ready), 128'd1);
        a_q.delete();
        b_q.delete();
        #2;
        rst_n = 1'b1;
        a_ready_drv = 1'b1;
        repeat (5) tick();
        chk("postrst_no_output", 128'(a_out_valid), 128'd0);
        send(SEQ_BLK, 1'b1, ft);
        drain();
        chk("postrst_count", 128'(a_count), 128'd1);

`ifdef AES_SHIFT_ROWS_PIPE_BYPASS_EN
        // bypassed block leaves unchanged
        a_bypass = 1'b1;
        send(SEQ_BLK, 1'b1, ft);
        a_bypass = 1'b0;
        tick();
        chk("bypass_block", a_out, SEQ_BLK);
        drain();
        chk("bypass_count", 128'(a_count), 128'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
